// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode receiver.
// Prefix byte values, frame FSM state encoding and the buffered key-event record.
// No logic; imported by ps2_event_fifo and ps2_scancode_rx.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_REL = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  typedef struct packed {
    logic       extended;
    logic       released;
    logic [7:0] code;
  } ps2_event_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Key-event FIFO: ps2_event_t storage, head presented combinationally (zeroed when empty).
// Latency: a push becomes visible at the head on the ce after it is accepted.
// Backpressure: push while full is dropped (dropped=1) unless a pop happens in the same ce.
// Ports: clock/reset/ce, push/push_dat, pop, head_dat, full, empty, dropped.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       push,
  input  ps2_event_t push_dat,
  input  logic       pop,
  output ps2_event_t head_dat,
  output logic       full,
  output logic       empty,
  output logic       dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  ps2_event_t    mem_q [DEPTH];
  ps2_event_t    mem_d [DEPTH];
  logic          do_push, do_pop;

  assign full     = (cnt_q == FULL_CNT);
  assign empty    = (cnt_q == '0);
  assign head_dat = empty ? '0 : mem_q[rd_q];

  always_comb begin
    do_pop  = ce && pop && !empty;
    // A pop in the same ce frees the slot, so a full FIFO can still accept.
    do_push = ce && push && (!full || do_pop);
    dropped = ce && push && full && !do_pop;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = rd_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: sync + deglitch pins, deserialise frames, fold E0/F0 prefixes into events.
// Latency: event pushed on the ce after the stop-bit strobe; valid rises on the following ce.
// Backpressure: valid/ready on the event FIFO; events arriving while full are dropped and overflow sticks.
// Ports: clock, reset (async high), ce, ps2[0]=clk ps2[1]=data, valid/ready, code/extended/released, error, overflow.
// Option: define PS2_TIMEOUT_EN to abort a frame after TIMEOUT_CYCLES ce ticks without a bit strobe.
module ps2_scancode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic [1:0] ps2,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] code,
  output logic       extended,
  output logic       released,
  output logic       error,
  output logic       overflow
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic          clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic          dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_ok_q, par_ok_d;
  logic          ext_q, ext_d, rel_q, rel_d;
  logic          evt_vld_q, evt_vld_d;
  ps2_event_t    evt_q, evt_d;
  logic          error_q, error_d;
  logic          ovf_q, ovf_d;
  logic          strobe;
  ps2_event_t    head;
  logic          fifo_full, fifo_empty, fifo_dropped;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_q, to_d;
`endif

  always_comb begin
    clk_s1_d  = clk_s1_q;
    clk_s2_d  = clk_s2_q;
    dat_s1_d  = dat_s1_q;
    dat_s2_d  = dat_s2_q;
    filt_d    = filt_q;
    fcnt_d    = fcnt_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    evt_vld_d = evt_vld_q;
    evt_d     = evt_q;
    error_d   = error_q;
    strobe    = 1'b0;
`ifdef PS2_TIMEOUT_EN
    to_d      = to_q;
`endif
    if (ce) begin
      clk_s1_d  = ps2[0];
      clk_s2_d  = clk_s1_q;
      dat_s1_d  = ps2[1];
      dat_s2_d  = dat_s1_q;
      error_d   = 1'b0;
      evt_vld_d = 1'b0;

      // Count consecutive samples disagreeing with the filtered level; flip on the FILTER_LEN-th.
      if (clk_s2_q != filt_q) begin
        if (fcnt_q == FILT_LAST) begin
          filt_d = clk_s2_q;
          fcnt_d = '0;
          strobe = filt_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end else begin
        fcnt_d = '0;
      end

      if (strobe) begin
        unique case (state_q)
          IDLE: begin
            if (!dat_s2_q) begin
              state_d   = DATA;
              bit_cnt_d = 3'd0;
            end
          end
          DATA: begin
            shift_d   = {dat_s2_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end
          PARITY: begin
            par_ok_d = ^{shift_q, dat_s2_q};
            state_d  = STOP;
          end
          STOP: begin
            state_d = IDLE;
            if (dat_s2_q && par_ok_q) begin
              if (shift_q == PS2_PREFIX_EXT) begin
                ext_d = 1'b1;
              end else if (shift_q == PS2_PREFIX_REL) begin
                rel_d = 1'b1;
              end else begin
                evt_vld_d      = 1'b1;
                evt_d.extended = ext_q;
                evt_d.released = rel_q;
                evt_d.code     = shift_q;
                ext_d          = 1'b0;
                rel_d          = 1'b0;
              end
            end else begin
              error_d = 1'b1;
              ext_d   = 1'b0;
              rel_d   = 1'b0;
            end
          end
          default: state_d = IDLE;
        endcase
      end

`ifdef PS2_TIMEOUT_EN
      // Counts ticks since the last strobe while a frame is in progress.
      if (state_q == IDLE || strobe) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        to_d    = '0;
        state_d = IDLE;
        ext_d   = 1'b0;
        rel_d   = 1'b0;
        error_d = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
`endif
    end
    ovf_d = ovf_q | fifo_dropped;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      fcnt_q    <= '0;
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_ok_q  <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      evt_vld_q <= 1'b0;
      evt_q     <= '0;
      error_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      clk_s1_q  <= clk_s1_d;
      clk_s2_q  <= clk_s2_d;
      dat_s1_q  <= dat_s1_d;
      dat_s2_q  <= dat_s2_d;
      filt_q    <= filt_d;
      fcnt_q    <= fcnt_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_ok_q  <= par_ok_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      evt_vld_q <= evt_vld_d;
      evt_q     <= evt_d;
      error_q   <= error_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef PS2_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .push    (evt_vld_q),
    .push_dat(evt_q),
    .pop     (ready),
    .head_dat(head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .dropped (fifo_dropped)
  );

  assign valid    = !fifo_empty;
  assign code     = head.code;
  assign extended = head.extended;
  assign released = head.released;
  assign error    = error_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: frames are bit-banged on the raw pins, events
// popped by the consumer are logged by a monitor and compared with hand-computed values.
module tb_ps2_scancode_rx;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ce = 1'b1;
  logic [1:0] ps2 = 2'b11;
  logic       valid;
  logic       ready = 1'b0;
  logic [7:0] code;
  logic       extended;
  logic       released;
  logic       error;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [9:0] ev_q[$];

  always #5 clock = ~clock;

  ps2_scancode_rx dut (
    .clock   (clock),
    .reset   (reset),
    .ce      (ce),
    .ps2     (ps2),
    .valid   (valid),
    .ready   (ready),
    .code    (code),
    .extended(extended),
    .released(released),
    .error   (error),
    .overflow(overflow)
  );

  // Record every handshake and every cycle the error output is high.
  always @(negedge clock) begin
    if (!reset && valid && ready && ce) ev_q.push_back({extended, released, code});
    if (!reset && error) err_cnt++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2[1] = b;
    wait_cyc(15);
    ps2[0] = 1'b0;
    wait_cyc(15);
    ps2[0] = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2[1] = 1'b1;
    wait_cyc(10);
  endtask

  task automatic pop_one();
    ready = 1'b1;
    wait_cyc(1);
    ready = 1'b0;
    wait_cyc(1);
  endtask

  task automatic do_reset();
    ps2   = 2'b11;
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (code !== 8'h00) begin errors++; $display("FAIL reset_code got %h want 00", code); end
    checks++; if ({extended, released} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {extended, released}); end
    checks++; if ({error, overflow} !== 2'b00) begin errors++; $display("FAIL reset_err_ovf got %b want 00", {error, overflow}); end
  endtask

  task automatic test_single();
    ev_q.delete(); err_cnt = 0; ready = 1'b1;
    send_byte(8'h1C, 1'b0);
    ready = 1'b0;
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h01C) begin errors++; $display("FAIL single_event got %h want 01c", ev_q[0]); end
    end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL single_error got %0d want 0", err_cnt); end
  endtask

  task automatic test_prefix();
    ev_q.delete(); err_cnt = 0; ready = 1'b1;
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hE1, 1'b0);
    ready = 1'b0;
    checks++; if (ev_q.size() != 6) begin errors++; $display("FAIL prefix_count got %0d want 6", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h375) begin errors++; $display("FAIL prefix_e0f0 got %h want 375", ev_q[0]); end
      checks++; if (ev_q[1] !== 10'h075) begin errors++; $display("FAIL prefix_plain got %h want 075", ev_q[1]); end
      checks++; if (ev_q[2] !== 10'h36B) begin errors++; $display("FAIL prefix_f0e0 got %h want 36b", ev_q[2]); end
      checks++; if (ev_q[3] !== 10'h11C) begin errors++; $display("FAIL prefix_rel got %h want 11c", ev_q[3]); end
      checks++; if (ev_q[4] !== 10'h0AA) begin errors++; $display("FAIL prefix_aa got %h want 0aa", ev_q[4]); end
      checks++; if (ev_q[5] !== 10'h0E1) begin errors++; $display("FAIL prefix_e1 got %h want 0e1", ev_q[5]); end
    end
  endtask

  task automatic test_parity();
    ev_q.delete(); err_cnt = 0; ready = 1'b1;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h16, 1'b1);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL parity_error_cycles got %0d want 1", err_cnt); end
    checks++; if (ev_q.size() != 0 || valid !== 1'b0) begin errors++; $display("FAIL parity_no_event got %0d valid %b want 0 0", ev_q.size(), valid); end
    send_byte(8'h16, 1'b0);
    ready = 1'b0;
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL parity_recover_count got %0d want 1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h016) begin errors++; $display("FAIL parity_recover got %h want 016", ev_q[0]); end
    end
  endtask

  task automatic test_glitch_and_reset();
    ev_q.delete(); err_cnt = 0; ready = 1'b1;
    ps2[1] = 1'b0;
    for (int g = 0; g < 6; g++) begin
      ps2[0] = 1'b0; wait_cyc(3);
      ps2[0] = 1'b1; wait_cyc(12);
    end
    ps2[1] = 1'b1;
    wait_cyc(10);
    send_byte(8'hE0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    ready = 1'b1;
    send_byte(8'h29, 1'b0);
    ready = 1'b0;
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL glitch_reset_count got %0d want 1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h029) begin errors++; $display("FAIL glitch_reset_event got %h want 029", ev_q[0]); end
    end
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL glitch_reset_error got %0d want 0", err_cnt); end
  endtask

  task automatic test_overflow();
    ev_q.delete(); err_cnt = 0; ready = 1'b0;
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (valid !== 1'b1 || code !== 8'h01) begin errors++; $display("FAIL ovf_head got %b/%h want 1/01", valid, code); end
    ce = 1'b0; ready = 1'b1;
    wait_cyc(4);
    ready = 1'b0; ce = 1'b1;
    checks++; if (ev_q.size() != 0 || code !== 8'h01) begin errors++; $display("FAIL ce_gated_pop got %0d/%h want 0/01", ev_q.size(), code); end
    for (int i = 0; i < 4; i++) pop_one();
    checks++; if (ev_q.size() != 4) begin errors++; $display("FAIL ovf_pop_count got %0d want 4", ev_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (ev_q[i] !== 10'(i + 1)) begin errors++; $display("FAIL ovf_pop%0d got %h want %h", i, ev_q[i], 10'(i + 1)); end
      end
    end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", valid); end
    ready = 1'b1; wait_cyc(3); ready = 1'b0;
    checks++; if (ev_q.size() != 4 || valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL empty_pop got %0d/%b/%b want 4/0/1", ev_q.size(), valid, overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared got %b want 0", overflow); end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    ev_q.delete(); err_cnt = 0; ready = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    wait_cyc(1900);
    checks++; if (err_cnt != 0) begin errors++; $display("FAIL timeout_early got %0d want 0", err_cnt); end
    wait_cyc(300);
    checks++; if (err_cnt != 1) begin errors++; $display("FAIL timeout_error got %0d want 1", err_cnt); end
    send_byte(8'h5A, 1'b0);
    ready = 1'b0;
    checks++; if (ev_q.size() != 1) begin errors++; $display("FAIL timeout_recover_count got %0d want 1", ev_q.size()); end
    else begin
      checks++; if (ev_q[0] !== 10'h05A) begin errors++; $display("FAIL timeout_recover got %h want 05a", ev_q[0]); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_parity();
    test_glitch_and_reset();
    test_overflow();
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
